// File: rtl/move_seq_ctrl.sv
// move_seq_ctrl: fetch/execute sequencer for register-move style instructions
// (mfhi, mflo, in, out, nop, halt) and optional mul/div.
// The mul/div support (states T4..T6 and alu_op) is compiled in only when
// the macro MOVE_SEQ_MULDIV_EN is defined. Without it, mul/div opcodes are
// illegal and alu_op stays 00.
// All control strobes are Moore outputs decoded from the state register and
// the opcode latched on entry to T3.
module move_seq_ctrl (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        HIout,
  output logic        LOout,
  output logic        HIin,
  output logic        LOin,
  output logic        InPortOut,
  output logic        OutPortIn,
  output logic        Yin,
  output logic        RZinLo,
  output logic        RZinHi,
  output logic        RZoutLo,
  output logic        RZoutHi,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    T0    = 4'd1,
    T1    = 4'd2,
    T2    = 4'd3,
    T3    = 4'd4,
    T4    = 4'd5,
    T5    = 4'd6,
    T6    = 4'd7,
    HALT  = 4'd8,
    FAULT = 4'd9
  } state_t;

  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  state_t      state_reg;
  state_t      state_next;
  logic [4:0]  opcode_reg;
  logic [15:0] retired_reg;
  logic        op_single;
  logic        op_muldiv;
  logic        retire;

  // Only the opcode field of ir is decoded; the operand fields belong to the datapath.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

  // Classify the latched opcode (never the live ir) for the execute phase.
  always_comb begin
    op_single = (opcode_reg == OP_MFHI) || (opcode_reg == OP_MFLO) ||
                (opcode_reg == OP_IN)   || (opcode_reg == OP_OUT)  ||
                (opcode_reg == OP_NOP);
`ifdef MOVE_SEQ_MULDIV_EN
    op_muldiv = (opcode_reg == OP_MUL) || (opcode_reg == OP_DIV);
`else
    op_muldiv = 1'b0;
`endif
    retire = ((state_reg == T3) && op_single) || (state_reg == T6);
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Opcode is captured on the edge that enters T3 and held through execute.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      opcode_reg <= 5'b00000;
    end else if (state_reg == T2) begin
      opcode_reg <= ir[31:27];
    end
  end

  // Retired-instruction counter, bumped on the last execute edge; wraps silently.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      retired_reg <= 16'h0000;
    end else if (retire) begin
      retired_reg <= retired_reg + 16'h0001;
    end
  end

  assign retired = retired_reg;

  // Next-state: fetch is unconditional, run is looked at only in IDLE and at
  // the end of execute so a falling run never cuts an instruction short.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (run) state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = T2;
      T2:   state_next = T3;
      T3: begin
        if (op_single) begin
          state_next = run ? T0 : IDLE;
        end else if (opcode_reg == OP_HALT) begin
          state_next = HALT;
        end else if (op_muldiv) begin
          state_next = T4;
        end else begin
          state_next = FAULT;
        end
      end
      T4:    state_next = T5;
      T5:    state_next = T6;
      T6:    state_next = run ? T0 : IDLE;
      HALT:  state_next = HALT;
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Moore strobe decode from state and latched opcode.
  always_comb begin
    PCout     = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    InPortOut = 1'b0;
    OutPortIn = 1'b0;
    Yin       = 1'b0;
    RZinLo    = 1'b0;
    RZinHi    = 1'b0;
    RZoutLo   = 1'b0;
    RZoutHi   = 1'b0;
    alu_op    = 2'b00;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_reg)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        case (opcode_reg)
          OP_MFHI: begin
            Gra = 1'b1; Rin = 1'b1; HIout = 1'b1;
          end
          OP_MFLO: begin
            Gra = 1'b1; Rin = 1'b1; LOout = 1'b1;
          end
          OP_IN: begin
            Gra = 1'b1; Rin = 1'b1; InPortOut = 1'b1;
          end
          OP_OUT: begin
            Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
          end
`ifdef MOVE_SEQ_MULDIV_EN
          OP_MUL, OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
`endif
          default: ;
        endcase
      end
`ifdef MOVE_SEQ_MULDIV_EN
      T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        RZinLo = 1'b1;
        RZinHi = 1'b1;
        alu_op = (opcode_reg == OP_MUL) ? 2'b01 : 2'b10;
      end
      T5: begin
        RZoutLo = 1'b1;
        LOin    = 1'b1;
      end
      T6: begin
        RZoutHi = 1'b1;
        HIin    = 1'b1;
      end
`endif
      HALT:  halted  = 1'b1;
      FAULT: illegal = 1'b1;
      default: ;
    endcase
  end

  // busy covers the whole fetch/execute window.
  assign busy = (state_reg == T0) || (state_reg == T1) || (state_reg == T2) ||
                (state_reg == T3) || (state_reg == T4) || (state_reg == T5) ||
                (state_reg == T6);

endmodule

// File: tb/tb_move_seq_ctrl.sv
// tb_move_seq_ctrl: directed scenarios plus randomized instruction streams,
// checked every cycle against an instruction-step reference model.
// Honours MOVE_SEQ_MULDIV_EN the same way as the design.
module tb_move_seq_ctrl;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run   = 1'b0;
  logic [31:0] ir    = 32'h0;
  logic PCout, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Grc, Rin, Rout, HIout, LOout, HIin, LOin;
  logic InPortOut, OutPortIn, Yin, RZinLo, RZinHi, RZoutLo, RZoutHi;
  logic [1:0]  alu_op;
  logic        busy, halted, illegal;
  logic [15:0] retired;

  move_seq_ctrl dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .HIout(HIout), .LOout(LOout), .HIin(HIin), .LOin(LOin),
    .InPortOut(InPortOut), .OutPortIn(OutPortIn), .Yin(Yin), .RZinLo(RZinLo),
    .RZinHi(RZinHi), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

`ifdef MOVE_SEQ_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  // Bit positions in the packed observation word.
  localparam int B_ILLEGAL = 0,  B_HALTED = 1,  B_BUSY = 2,  B_ALU = 3;
  localparam int B_RZOUTHI = 5,  B_RZOUTLO = 6, B_RZINHI = 7, B_RZINLO = 8;
  localparam int B_YIN = 9,      B_OUTPORTIN = 10, B_INPORTOUT = 11;
  localparam int B_LOIN = 12,    B_HIIN = 13,   B_LOOUT = 14, B_HIOUT = 15;
  localparam int B_ROUT = 16,    B_RIN = 17,    B_GRC = 18,   B_GRB = 19;
  localparam int B_GRA = 20,     B_IRIN = 21,   B_MDROUT = 22, B_MDRIN = 23;
  localparam int B_READ = 24,    B_MARIN = 25,  B_INCPC = 26, B_PCOUT = 27;

  logic [27:0] obs_word;
  assign obs_word = {PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Gra, Grb,
                     Grc, Rin, Rout, HIout, LOout, HIin, LOin, InPortOut,
                     OutPortIn, Yin, RZinLo, RZinHi, RZoutLo, RZoutHi, alu_op,
                     busy, halted, illegal};

  // Reference model: mode plus step index within the current instruction.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int          mdl_mode = M_IDLE;
  int          mdl_k    = 0;
  logic [4:0]  mdl_op   = 5'b0;
  logic [15:0] mdl_ret  = 16'h0;
  int          n_total  = 0;
  int          n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_md(input logic [4:0] op);
    return MULDIV && (op == OP_MUL || op == OP_DIV);
  endfunction

  function automatic bit is_single(input logic [4:0] op);
    return op == OP_MFHI || op == OP_MFLO || op == OP_IN || op == OP_OUT || op == OP_NOP;
  endfunction

  // Expected outputs for the model's current position.
  function automatic logic [27:0] exp_word();
    logic [27:0] w;
    w = '0;
    case (mdl_mode)
      M_HALT:  w[B_HALTED] = 1'b1;
      M_FAULT: w[B_ILLEGAL] = 1'b1;
      M_RUN: begin
        w[B_BUSY] = 1'b1;
        case (mdl_k)
          0: begin w[B_PCOUT] = 1'b1; w[B_MARIN] = 1'b1; w[B_INCPC] = 1'b1; end
          1: begin w[B_READ] = 1'b1; w[B_MDRIN] = 1'b1; end
          2: begin w[B_MDROUT] = 1'b1; w[B_IRIN] = 1'b1; end
          3: begin
            if (mdl_op == OP_MFHI) begin w[B_GRA] = 1'b1; w[B_RIN] = 1'b1; w[B_HIOUT] = 1'b1; end
            if (mdl_op == OP_MFLO) begin w[B_GRA] = 1'b1; w[B_RIN] = 1'b1; w[B_LOOUT] = 1'b1; end
            if (mdl_op == OP_IN)   begin w[B_GRA] = 1'b1; w[B_RIN] = 1'b1; w[B_INPORTOUT] = 1'b1; end
            if (mdl_op == OP_OUT)  begin w[B_GRA] = 1'b1; w[B_ROUT] = 1'b1; w[B_OUTPORTIN] = 1'b1; end
            if (is_md(mdl_op))     begin w[B_GRB] = 1'b1; w[B_ROUT] = 1'b1; w[B_YIN] = 1'b1; end
          end
          4: begin
            w[B_GRC] = 1'b1; w[B_ROUT] = 1'b1; w[B_RZINLO] = 1'b1; w[B_RZINHI] = 1'b1;
            w[B_ALU+1 -: 2] = (mdl_op == OP_MUL) ? 2'b01 : 2'b10;
          end
          5: begin w[B_RZOUTLO] = 1'b1; w[B_LOIN] = 1'b1; end
          6: begin w[B_RZOUTHI] = 1'b1; w[B_HIIN] = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return w;
  endfunction

  // Advance the model across one rising edge with the inputs seen there.
  task automatic model_edge(input logic r, input logic [31:0] i);
    case (mdl_mode)
      M_IDLE: if (r) begin mdl_mode = M_RUN; mdl_k = 0; end
      M_RUN: begin
        if (mdl_k == 2) mdl_op = i[31:27];
        if (mdl_k == (is_md(mdl_op) ? 6 : 3)) begin
          if (mdl_op == OP_HALT) begin
            mdl_mode = M_HALT;
            $display("instr op=%b -> halt retired=%h", mdl_op, mdl_ret);
          end else if (!is_single(mdl_op) && !is_md(mdl_op)) begin
            mdl_mode = M_FAULT;
            $display("instr op=%b -> illegal retired=%h", mdl_op, mdl_ret);
          end else begin
            mdl_ret = mdl_ret + 16'h1;
            $display("instr op=%b retired=%h", mdl_op, mdl_ret);
            if (r) mdl_k = 0;
            else mdl_mode = M_IDLE;
          end
        end else begin
          mdl_k++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outs(input string tag);
    check_val({tag, "_outs"}, {4'h0, obs_word}, {4'h0, exp_word()});
    check_val({tag, "_retired"}, {16'h0, retired}, {16'h0, mdl_ret});
  endtask

  // One clock: drive inputs at the falling edge, check at the next falling edge.
  task automatic step(input logic r, input logic [31:0] i);
    run = r;
    ir  = i;
    @(posedge clock);
    model_edge(r, i);
    @(negedge clock);
    check_outs("step");
  endtask

  // Assert clear between edges; outputs must drop before any clock arrives.
  task automatic do_reset();
    clear = 1'b0;
    #1;
    mdl_mode = M_IDLE; mdl_k = 0; mdl_op = 5'b0; mdl_ret = 16'h0;
    check_outs("reset_async");
    @(posedge clock);
    @(negedge clock);
    check_outs("reset_held");
    clear = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [26:0] rest;
    rest = 27'($urandom);
    return {op, rest};
  endfunction

  function automatic logic [4:0] pick_op(input int r);
    case (r)
      0, 7:   return OP_MFHI;
      1, 8:   return OP_MFLO;
      2, 9:   return OP_IN;
      3, 10:  return OP_OUT;
      4, 11:  return OP_NOP;
      5, 12:  return OP_MUL;
      6, 13:  return OP_DIV;
      14:     return OP_HALT;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    @(negedge clock);
    do_reset();

    // mfhi R1, then drop run at the end of execute.
    repeat (4) step(1'b1, 32'hC0800000);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // out followed by in with run held high, no idle gap.
    repeat (4) step(1'b1, mk(OP_OUT));
    repeat (4) step(1'b1, mk(OP_IN));
    step(1'b0, mk(OP_NOP));

    // mul (or illegal without mul/div), run dropped after the first fetch edge.
    step(1'b1, mk(OP_MUL));
    repeat (9) step(1'b0, mk(OP_MUL));
    if (mdl_mode != M_IDLE) do_reset();

    // div with run held through to the next fetch.
    repeat (8) step(1'b1, mk(OP_DIV));
    repeat (4) step(1'b0, 32'h0);
    if (mdl_mode != M_IDLE) do_reset();

    // Undefined opcode: FAULT sticks while run toggles, cleared only by reset.
    repeat (4) step(1'b1, mk(5'b00001));
    for (int i = 0; i < 6; i++) step(i[0], 32'($urandom));
    do_reset();

    // halt: sticky HALT.
    repeat (4) step(1'b1, mk(OP_HALT));
    repeat (4) step(1'b1, mk(OP_NOP));
    do_reset();

    // Reset asserted in the middle of T1.
    repeat (2) step(1'b1, mk(OP_MFLO));
    do_reset();
    step(1'b0, 32'h0);

    // Counter wrap: preload close to the top, then retire two nops.
    dut.retired_reg = 16'hFFFE;
    mdl_ret = 16'hFFFE;
    repeat (8) step(1'b1, mk(OP_NOP));
    step(1'b0, 32'h0);

    // Randomized instruction streams with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ((mdl_mode == M_HALT || mdl_mode == M_FAULT) && $urandom_range(0, 3) == 0)
        do_reset();
      else if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        step($urandom_range(0, 9) < 7, mk(pick_op($urandom_range(0, 15))));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/move_seq_ctrl.md
MOVE_SEQ_CTRL -- requirements
Module: move_seq_ctrl

Interface
REQ-001 SHALL have ports `clock` (in, 1): single rising-edge clock; `clear` (in, 1): reset, asynchronous, active-low.
REQ-002 SHALL have `run` (in, 1): level request to execute; `ir` (in, 32): instruction register contents, opcode = ir[31:27].
REQ-003 SHALL have fetch outputs, all out, 1 bit: `PCout`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`.
REQ-004 SHALL have execute outputs, all out, 1 bit: `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `HIout`, `LOout`, `HIin`, `LOin`, `InPortOut`, `OutPortIn`, `Yin`, `RZinLo`, `RZinHi`, `RZoutLo`, `RZoutHi`.
REQ-005 SHALL have status outputs: `alu_op` (out, 2): 00 none, 01 mul, 10 div; `busy` (out, 1); `halted` (out, 1); `illegal` (out, 1); `retired` (out, 16): retired-instruction count.

Function
REQ-006 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT.
REQ-007 SHALL transition IDLE->T0 on a clock edge with run=1; otherwise SHALL remain in IDLE.
REQ-008 SHALL perform fetch: T0 asserts PCout, MARin, IncPC; T1 asserts Read, MDRin; T2 asserts MDRout, IRin; then T0->T1->T2->T3 unconditionally.
REQ-009 SHALL latch ir[31:27] into an opcode register on the T3 entry edge; T3..T6 decode from the latched copy only.
REQ-010 SHALL decode mfhi=5'b11000 as T3: Gra, Rin, HIout.
REQ-011 SHALL decode mflo=5'b11001 as T3: Gra, Rin, LOout.
REQ-012 SHALL decode in=5'b10110 as T3: Gra, Rin, InPortOut.
REQ-013 SHALL decode out=5'b10111 as T3: Gra, Rout, OutPortIn.
REQ-014 SHALL decode nop=5'b11010 as T3 with no execute output asserted.
REQ-015 SHALL return to T0 after T3 for single-cycle ops when run=1, and to IDLE when run=0.
REQ-016 SHALL decode halt=5'b11011 as T3->HALT; HALT SHALL exit only via reset; halted=1 in HALT.
REQ-017 SHALL send any undefined opcode from T3 to FAULT with no execute strobe asserted; illegal=1 in FAULT; FAULT SHALL exit only via reset.
REQ-018 SHALL decode all outputs as Moore outputs of state and latched opcode, with each strobe high for exactly one cycle and no glitch at state boundaries.
REQ-019 SHALL drive busy=1 in T0..T6 and 0 elsewhere.
REQ-020 SHALL increment retired by 1 on the final execute edge of each mfhi, mflo, in, out, nop or mul/div; halt and illegal opcodes SHALL NOT count.
REQ-021 SHALL wrap retired from 16'hFFFF to 16'h0000 without a flag.
REQ-022 SHALL finish an instruction already in T0..T6 when run falls mid-instruction; run is sampled only in IDLE and at the end of execute.

Reset
REQ-023 SHALL, while clear=0, force state=IDLE, opcode register=0, retired=0 and every 1-bit output=0, and alu_op=00, regardless of the clock.
REQ-024 SHALL abort any in-flight instruction immediately on reset assertion with no partial strobe after assertion; the first fetch after release SHALL need run=1 in IDLE.

Configuration
REQ-025 SHALL compile mul/div support only when macro MOVE_SEQ_MULDIV_EN is defined.
REQ-026 SHALL, with MOVE_SEQ_MULDIV_EN defined, decode mul=5'b01111 and div=5'b10000 as T3: Grb, Rout, Yin; T4: Grc, Rout, RZinLo, RZinHi, alu_op=01 (mul) or 10 (div); T5: RZoutLo, LOin; T6: RZoutHi, HIin; then follow the REQ-015 exit rule.
REQ-027 SHALL, without MOVE_SEQ_MULDIV_EN, route opcodes 01111 and 10000 to FAULT, hold alu_op at 00 permanently, and make states T4..T6 unreachable.

Verification
REQ-028 SHALL cover: reset release, run=1, ir=32'hC0800000 (mfhi R1) -> T0..T3 strobes in order, Gra+Rin+HIout high exactly in cycle 4, retired=1.
REQ-029 SHALL cover: out then in back-to-back with run held high -> OutPortIn on cycle 4, InPortOut on cycle 8, retired=2, no idle cycle between instructions.
REQ-030 SHALL cover: with MOVE_SEQ_MULDIV_EN, ir opcode 01111 -> alu_op=01 only in T4, LOin in T5, HIin in T6, busy high 7 cycles; without the macro the same opcode -> FAULT, illegal=1, retired unchanged.
REQ-031 SHALL cover: opcode 5'b00001 -> FAULT after T3, all strobes 0, illegal stays 1 while run toggles; clear=0 -> IDLE, illegal=0.
REQ-032 SHALL cover: preload retired to 16'hFFFE via 2 nop instructions near wrap -> 16'hFFFF then 16'h0000.
REQ-033 SHALL cover: clear asserted mid-T1 -> all outputs 0 before the next clock edge; run=0 mid-mul -> completes T6 then IDLE.
